// File: rtl/exec_unit.sv
// Two-stage execution unit: register file, arith/logic/shift ALU and a persistent flag register,
// with valid/ready on both the instruction and result sides and forwarding from the ALU stage.
module exec_unit #(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [1:0]               op_class_i,
    input  logic [1:0]               op_sub_i,
    input  logic [ADDRESS_WIDTH-1:0] dst_i,
    input  logic [ADDRESS_WIDTH-1:0] src_a_i,
    input  logic [ADDRESS_WIDTH-1:0] src_b_i,
    input  logic                     use_imm_i,
    input  logic [WORD_WIDTH-1:0]    imm_i,
    input  logic                     wb_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [WORD_WIDTH-1:0]    res_data_o,
    output logic [4:0]               res_flags_o,
    output logic [4:0]               flags_o,
    input  logic                     host_we_i,
    input  logic [ADDRESS_WIDTH-1:0] host_addr_i,
    input  logic [WORD_WIDTH-1:0]    host_wdata_i,
    output logic [WORD_WIDTH-1:0]    host_rdata_o
);

    localparam int unsigned SHAMT_WIDTH = $clog2(WORD_WIDTH);
    localparam int unsigned REG_COUNT   = 2 ** ADDRESS_WIDTH;
    localparam int unsigned MSB         = WORD_WIDTH - 1;
    localparam int unsigned DW          = 2 * WORD_WIDTH;

    // Flag vector layout {SF,PF,OF,ZF,CF}
    localparam int unsigned FlagCf = 0;

    typedef enum logic [1:0] {
        ClsArith = 2'd0,
        ClsLogic = 2'd1,
        ClsShl   = 2'd2,
        ClsShr   = 2'd3
    } op_class_e;

    // Register file
    logic [WORD_WIDTH-1:0] regs_q [REG_COUNT];
    logic [WORD_WIDTH-1:0] regs_d [REG_COUNT];

    // Stage A
    logic                     a_valid_q, a_valid_d;
    op_class_e                a_class_q, a_class_d;
    logic [1:0]               a_sub_q, a_sub_d;
    logic [ADDRESS_WIDTH-1:0] a_dst_q, a_dst_d;
    logic                     a_wb_q, a_wb_d;
    logic [WORD_WIDTH-1:0]    a_opa_q, a_opa_d;
    logic [WORD_WIDTH-1:0]    a_opb_q, a_opb_d;

    // Output stage and flag register
    logic                  res_valid_q, res_valid_d;
    logic [WORD_WIDTH-1:0] res_data_q, res_data_d;
    logic [4:0]            res_flags_q, res_flags_d;
    logic [4:0]            flags_q, flags_d;

    logic advance;
    logic accept;

    // ALU signals
    logic [WORD_WIDTH-1:0]  alu_res;
    logic                   alu_cf;
    logic                   alu_of;
    logic [4:0]             alu_flags;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   cf_in;
    logic                   carry;
    logic [WORD_WIDTH:0]    sum;
    logic [WORD_WIDTH:0]    shl_w;
    logic [WORD_WIDTH:0]    shr_w;
    logic [WORD_WIDTH:0]    sar_w;
    logic [DW-1:0]          rol_w;
    logic [DW-1:0]          ror_w;

    logic                  fwd_a, fwd_b;
    logic [WORD_WIDTH-1:0] opa_rd, opb_rd;

    assign advance       = a_valid_q & (~res_valid_q | res_ready_i);
    assign instr_ready_o = ~a_valid_q | advance;
    assign accept        = instr_valid_i & instr_ready_o;

    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_flags_o  = res_flags_q;
    assign flags_o      = flags_q;
    assign host_rdata_o = regs_q[host_addr_i];

    // The instruction leaving stage A this cycle writes its result at the same edge, so a
    // dependent operand must be taken straight from the ALU.
    assign fwd_a  = advance & a_wb_q & (a_dst_q == src_a_i);
    assign fwd_b  = advance & a_wb_q & (a_dst_q == src_b_i);
    assign opa_rd = fwd_a ? alu_res : regs_q[src_a_i];
    assign opb_rd = use_imm_i ? imm_i : (fwd_b ? alu_res : regs_q[src_b_i]);

    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        shamt   = a_opb_q[SHAMT_WIDTH-1:0];
        cf_in   = flags_q[FlagCf];
        carry   = a_sub_q[0] & cf_in;
        sum     = '0;
        shl_w   = {1'b0, a_opa_q} << shamt;
        shr_w   = {a_opa_q, 1'b0} >> shamt;
        sar_w   = $signed({a_opa_q, 1'b0}) >>> shamt;
        rol_w   = {a_opa_q, a_opa_q} << shamt;
        ror_w   = {a_opa_q, a_opa_q} >> shamt;

        unique case (a_class_q)
            ClsArith: begin
                if (!a_sub_q[1]) begin
                    sum    = {1'b0, a_opa_q} + {1'b0, a_opb_q} + {{WORD_WIDTH{1'b0}}, carry};
                    alu_of = (a_opa_q[MSB] == a_opb_q[MSB]) & (sum[MSB] != a_opa_q[MSB]);
                end else begin
                    sum    = {1'b0, a_opa_q} - {1'b0, a_opb_q} - {{WORD_WIDTH{1'b0}}, carry};
                    alu_of = (a_opa_q[MSB] != a_opb_q[MSB]) & (sum[MSB] != a_opa_q[MSB]);
                end
                alu_res = sum[MSB:0];
                alu_cf  = sum[WORD_WIDTH];
            end
            ClsLogic: begin
                unique case (a_sub_q)
                    2'd0: alu_res = a_opa_q & a_opb_q;
                    2'd1: alu_res = a_opa_q | a_opb_q;
                    2'd2: alu_res = a_opa_q ^ a_opb_q;
                    2'd3: alu_res = a_opa_q & ~a_opb_q;
                endcase
            end
            ClsShl: begin
                unique case (a_sub_q)
                    2'd1: begin
                        alu_res = rol_w[DW-1 -: WORD_WIDTH];
                        alu_cf  = alu_res[0];
                    end
                    2'd2: begin
                        alu_res = {a_opa_q[MSB-1:0], cf_in};
                        alu_cf  = a_opa_q[MSB];
                    end
                    default: begin
                        alu_res = shl_w[MSB:0];
                        alu_cf  = shl_w[WORD_WIDTH];
                    end
                endcase
                if (a_sub_q != 2'd2 && shamt == '0) begin
                    alu_res = a_opa_q;
                    alu_cf  = cf_in;
                end
                alu_of = a_opa_q[MSB] ^ alu_res[MSB];
            end
            ClsShr: begin
                unique case (a_sub_q)
                    2'd0: begin
                        alu_res = shr_w[WORD_WIDTH:1];
                        alu_cf  = shr_w[0];
                    end
                    2'd1: begin
                        alu_res = sar_w[WORD_WIDTH:1];
                        alu_cf  = sar_w[0];
                    end
                    2'd2: begin
                        alu_res = ror_w[MSB:0];
                        alu_cf  = alu_res[MSB];
                    end
                    2'd3: begin
                        alu_res = {cf_in, a_opa_q[MSB:1]};
                        alu_cf  = a_opa_q[0];
                    end
                endcase
                if (a_sub_q != 2'd3 && shamt == '0) begin
                    alu_res = a_opa_q;
                    alu_cf  = cf_in;
                end
                alu_of = a_opa_q[MSB] ^ alu_res[MSB];
            end
        endcase
    end

    assign alu_flags = {alu_res[MSB], ~^alu_res, alu_of, (alu_res == '0), alu_cf};

    always_comb begin
        a_valid_d = a_valid_q;
        a_class_d = a_class_q;
        a_sub_d   = a_sub_q;
        a_dst_d   = a_dst_q;
        a_wb_d    = a_wb_q;
        a_opa_d   = a_opa_q;
        a_opb_d   = a_opb_q;
        if (accept) begin
            a_valid_d = 1'b1;
            a_class_d = op_class_e'(op_class_i);
            a_sub_d   = op_sub_i;
            a_dst_d   = dst_i;
            a_wb_d    = wb_i;
            a_opa_d   = opa_rd;
            a_opb_d   = opb_rd;
        end else if (advance) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        if (advance) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_res;
            res_flags_d = alu_flags;
            flags_d     = alu_flags;
        end else if (res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // Writeback is applied last so it overrides a host write to the same register.
    always_comb begin
        regs_d = regs_q;
        if (host_we_i) begin
            regs_d[host_addr_i] = host_wdata_i;
        end
        if (advance && a_wb_q) begin
            regs_d[a_dst_q] = alu_res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_valid_q   <= 1'b0;
            a_class_q   <= ClsArith;
            a_sub_q     <= '0;
            a_dst_q     <= '0;
            a_wb_q      <= 1'b0;
            a_opa_q     <= '0;
            a_opb_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            flags_q     <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            a_valid_q   <= a_valid_d;
            a_class_q   <= a_class_d;
            a_sub_q     <= a_sub_d;
            a_dst_q     <= a_dst_d;
            a_wb_q      <= a_wb_d;
            a_opa_q     <= a_opa_d;
            a_opb_q     <= a_opb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, pipelined execution unit combining a register file, arithmetic, logic and left/right shift datapaths with a persistent flag register. It accepts one instruction per cycle over a valid/ready handshake and executes it in two stages. Register operands are forwarded from the in-flight instruction. Results and flags are presented on a back-pressurable output port. It sits between the instruction sequencer and result consumers, replacing the flat top-level that wired the individual blocks together.

## Interface
- WORD_WIDTH, 8: datapath width, ≥4, power of two.
- ADDRESS_WIDTH, 3: register address width; REG_COUNT = 2**ADDRESS_WIDTH.
- SHAMT_WIDTH, $clog2(WORD_WIDTH): derived; shift-amount width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- instr_valid_i  in  1  instruction valid.
- instr_ready_o  out  1  instruction accepted when valid and ready are both high.
- op_class_i  in  2  0 arith, 1 logic, 2 left shift, 3 right shift.
- op_sub_i  in  2  sub-operation within the class.
- dst_i  in  ADDRESS_WIDTH  destination register.
- src_a_i, src_b_i  in  ADDRESS_WIDTH  source registers.
- use_imm_i  in  1  selects imm_i as operand B instead of R[src_b_i].
- imm_i  in  WORD_WIDTH  immediate.
- wb_i  in  1  1 writes the result to R[dst]; 0 updates flags only (compare/test).
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.
- res_data_o  out  WORD_WIDTH  result.
- res_flags_o  out  5  {SF,PF,OF,ZF,CF} of that result.
- flags_o  out  5  current flag register.
- host_we_i  in  1  host register write.
- host_addr_i  in  ADDRESS_WIDTH  host write/read address.
- host_wdata_i  in  WORD_WIDTH  host write data.
- host_rdata_o  out  WORD_WIDTH  R[host_addr_i], combinational, no forwarding.

## Operation
- Stage A register holds the op, operands, dst, wb and a_valid. The output register holds the result, result flags and res_valid_o.
- advance = a_valid & (~res_valid_o | res_ready_i).
- instr_ready_o = ~a_valid | advance.
- On accept, read operands into stage A. If advance is high and A.wb is high and A.dst equals the source, the operand is forwarded from the ALU result. Otherwise it comes from the register file.
- On advance:
  - ALU output is latched into res_data_o and res_flags_o, and res_valid_o is set.
  - The flag register is updated.
  - If wb is high, R[dst] is written.
- Without advance, if res_ready_i is high, res_valid_o clears.
- Host write occurs when host_we_i is high. If it targets the same register in the same cycle as a writeback, the writeback wins and the host write is dropped.
- Flags (common to all classes):
  - ZF = (r==0).
  - SF = r[msb].
  - PF = ~^r, i.e. 1 for even parity.
- Arith class:
  - 0 ADD, 1 ADC (carry-in = CF from the flag register), 2 SUB, 3 SBB (borrow-in = CF).
  - CF is carry-out for ADD/ADC and borrow for SUB/SBB.
  - OF is signed overflow.
- Logic class:
  - 0 AND, 1 OR, 2 XOR, 3 ANDN (a & ~b).
  - CF = 0, OF = 0.
- Shift classes:
  - Shift amount n = b[SHAMT_WIDTH-1:0]. Operations marked "by 1" ignore b.
  - Left: 0 SHL, 1 ROL, 2 RCL by 1, 3 SHL.
  - Right: 0 SHR, 1 SAR, 2 ROR, 3 RCR by 1.
  - CF = last bit shifted or rotated out. For ROL, CF = r[0]; for ROR, CF = r[msb].
  - If n==0 on an n-based op: r = a and CF is unchanged.
  - OF = a[msb] ^ r[msb].

## Timing
- Reset (rst_ni low at a rising edge):
  - All registers, the flag register, stage A, the output register and res_valid_o are cleared to 0.
  - instr_ready_o = 1 once stage A is empty.
  - An instruction presented during reset is not accepted.
  - Reset mid-operation discards in-flight instructions with no writeback.
- Latency: an instruction accepted at edge t has res_valid_o high from edge t+1. Its register and flag writes are visible to an instruction accepted at edge t+1, with no bubble.
- Throughput: one instruction per cycle while res_ready_i is high.
- Stall behaviour:
  - res_data_o and res_flags_o are held stable while res_valid_o is high and res_ready_i is low.
  - Stage A is held during the stall; instr_ready_o drops while stage A is full.
- Result order equals accept order; no instruction is lost or duplicated.

## Test plan
- Reset: hold rst_ni low for 2 cycles with instr_valid_i=1 -> res_valid_o=0, flags_o=0, all host reads return 0, no instruction accepted; instr_ready_o=1 after release.
- Host writes R1=0x7F, R2=0x01, then ADD R3,R1,R2 -> res_data_o=0x80 at edge t+1, res_flags_o SF=1, OF=1, CF=0, ZF=0, PF=0.
- SUB R4,R3,imm 0x80 issued the cycle after the previous instruction -> forwarded result 0x00 with ZF=1, PF=1, CF=0; R4 reads 0x00.
- ADD with wb=0, R1=0xFF, imm 0x01 -> flags only, CF=1, R1 unchanged; next ADC R5,R0,imm 0x00 -> 0x01 with CF=0.
- Shifts: SAR 0x90 by 2 -> 0xE4, CF=0. ROL 0x81 by 1 -> 0x03, CF=1. RCR 0x02 with CF=1 -> 0x81, CF=0.
- Backpressure:
  - Issue 3 back-to-back ADDs with res_ready_i=0 for 3 cycles -> output held, instr_ready_o=0 once stage A is full; on release, the 3 results appear in order.
  - Reset asserted while stalled -> nothing is written back.
